// File: rtl/skinny_sbox_layer_isw1_seq.sv
// rtl/skinny_sbox_layer_isw1_seq.sv - byte-serial SKINNY S-box layer sequencer for a 2-share ISW-1 sbox8
// Optional macro SBOX_PRECHARGE_EN: one all-zero sbox input cycle between consecutive bytes.
module skinny_sbox_layer_isw1_seq #(
  parameter int SBOX_CYCLES = 8,
  parameter int NBYTES      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] st1_i,
  input  logic [8*NBYTES-1:0] st0_i,
  input  logic [7:0]          rnd_i,
  output logic                rnd_req,
  output logic [7:0]          sb_si1,
  output logic [7:0]          sb_si0,
  output logic [7:0]          sb_r,
  input  logic [7:0]          sb_bo1,
  input  logic [7:0]          sb_bo0,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] st1_o,
  output logic [8*NBYTES-1:0] st0_o
);

  localparam int W  = 8 * NBYTES;
  localparam int BW = $clog2(NBYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0]    C_LAST = 4'(SBOX_CYCLES);
  localparam logic [BW-1:0] K_LAST = BW'(NBYTES - 1);

  logic [1:0]    r_state;
  logic [3:0]    r_cyc;
  logic [BW-1:0] r_byte;
  logic [W-1:0]  r_sh1;
  logic [W-1:0]  r_sh0;
  logic [W-1:0]  r_st1_o;
  logic [W-1:0]  r_st0_o;
  logic [7:0]    r_si1;
  logic [7:0]    r_si0;
  logic [7:0]    r_r;

  logic          w_accept;
  logic          w_last_byte;
  logic          w_hold_end;
  logic          w_load;
  logic          w_zero;
  logic [W-1:0]  w_src1;
  logic [W-1:0]  w_src0;

  assign w_accept    = (r_state == S_IDLE) && in_valid;
  assign w_last_byte = (r_byte == K_LAST);

`ifdef SBOX_PRECHARGE_EN
  logic r_pre;

  // w_hold_end: last cycle of a byte's hold window; w_load: edge presenting a new byte and mask.
  assign w_hold_end = (r_state == S_HOLD) && !r_pre && (r_cyc == C_LAST);
  assign w_load     = w_accept || ((r_state == S_HOLD) && r_pre);
  assign w_zero     = w_hold_end;

  // One precharge cycle follows every captured byte except the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= 1'b0;
    end else begin
      r_pre <= w_hold_end && !w_last_byte;
    end
  end
`else
  assign w_hold_end = (r_state == S_HOLD) && (r_cyc == C_LAST);
  assign w_load     = w_accept || (w_hold_end && !w_last_byte);
  assign w_zero     = w_hold_end && w_last_byte;
`endif

  // The mask register is written only on load edges, so rnd_req marks exactly those edges.
  assign rnd_req = w_load;

  // Fresh input is taken directly from the ports on acceptance, otherwise from the shift registers.
  assign w_src1 = (r_state == S_IDLE) ? st1_i : r_sh1;
  assign w_src0 = (r_state == S_IDLE) ? st0_i : r_sh0;

  // Control FSM with per-byte hold counter and byte index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cyc   <= 4'd0;
      r_byte  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= S_HOLD;
            r_cyc   <= 4'd1;
            r_byte  <= '0;
          end
        end
        S_HOLD: begin
          if (w_hold_end && w_last_byte) begin
            r_state <= S_DONE;
          end
          if (w_load) begin
            r_cyc  <= 4'd1;
            r_byte <= r_byte + 1'b1;
          end else if (!w_hold_end) begin
            r_cyc <= r_cyc + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sbox input registers and per-share byte shifters; each share stays in its own path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh1 <= '0;
      r_sh0 <= '0;
      r_si1 <= 8'd0;
      r_si0 <= 8'd0;
      r_r   <= 8'd0;
    end else if (w_load) begin
      r_si1 <= w_src1[7:0];
      r_si0 <= w_src0[7:0];
      r_r   <= rnd_i;
      r_sh1 <= w_src1 >> 8;
      r_sh0 <= w_src0 >> 8;
    end else if (w_zero) begin
      r_si1 <= 8'd0;
      r_si0 <= 8'd0;
      r_r   <= 8'd0;
    end
  end

  // Sbox results shift in from the top so byte k lands at bits [8k+7:8k] after the last byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st1_o <= '0;
      r_st0_o <= '0;
    end else if (w_hold_end) begin
      r_st1_o <= {sb_bo1, r_st1_o[W-1:8]};
      r_st0_o <= {sb_bo0, r_st0_o[W-1:8]};
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sb_si1    = r_si1;
  assign sb_si0    = r_si0;
  assign sb_r      = r_r;
  assign st1_o     = r_st1_o;
  assign st0_o     = r_st0_o;

endmodule
